// File: rtl/johnson_seq_monitor_if.sv
// Bundles the sample stream feeding johnson_seq_monitor and the decoded /
// status results it returns.
//   master : producer side (drives q_in, q_valid, err_clr; reads results)
//   slave  : monitor side  (reads q_in, q_valid, err_clr; drives results)
// Signals:
//   q_in       Johnson code from the counter
//   q_valid    q_in is sampled only when high
//   err_clr    synchronous clear of err_count
//   phase      one-hot decoded phase, zero when no legal code is held
//   phase_idx  binary phase index
//   illegal    pulse: sampled code is not a Johnson code
//   step_err   pulse: legal code that is not the previous index + 1
//   wrap       pulse: correct step from the last index back to 0
//   locked     level: sequence tracked and verified
//   err_count  saturating count of illegal + step_err events
interface johnson_seq_monitor_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  localparam int PH_W  = 2 * WIDTH;
  localparam int IDX_W = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] q_in;
  logic             q_valid;
  logic             err_clr;
  logic [PH_W-1:0]  phase;
  logic [IDX_W-1:0] phase_idx;
  logic             illegal;
  logic             step_err;
  logic             wrap;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  modport master (
    output q_in, q_valid, err_clr,
    input  phase, phase_idx, illegal, step_err, wrap, locked, err_count
  );

  modport slave (
    input  q_in, q_valid, err_clr,
    output phase, phase_idx, illegal, step_err, wrap, locked, err_count
  );
endinterface

// File: rtl/johnson_seq_monitor.sv
// Downstream monitor for a Johnson counter output. Each valid sample is
// decoded to a one-hot phase and a binary index, checked for legality and
// for stepping exactly one phase forward, and used to drive a small
// NOREF/TRACK/LOCKED tracker plus a saturating error counter. All outputs
// are registered and reflect the sample taken on the previous valid edge.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  johnson_seq_monitor_if slave modport (sample in, results out)
module johnson_seq_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input logic               clk,
  input logic               rst,
  johnson_seq_monitor_if.slave bus
);
  localparam int PH_W  = 2 * WIDTH;
  localparam int IDX_W = $clog2(2 * WIDTH);
  localparam int GC_W  = $clog2(LOCK_CNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * WIDTH - 1);

  typedef enum logic [1:0] {NOREF, TRACK, LOCKED} state_t;

  // Returns {legal, idx}. Codes with k ones packed against the MSB map to
  // idx k (k=0..WIDTH); k ones packed against the LSB map to idx 2W-k.
  function automatic logic [IDX_W:0] decode(input logic [WIDTH-1:0] code);
    logic [IDX_W:0]   res;
    logic [WIDTH-1:0] all_ones;
    logic [WIDTH-1:0] pat;
    res      = '0;
    all_ones = '1;
    for (int k = 0; k <= WIDTH; k++) begin
      pat = ~(all_ones >> k);
      if (code == pat) res = {1'b1, IDX_W'(k)};
    end
    for (int k = 1; k < WIDTH; k++) begin
      pat = all_ones >> (WIDTH - k);
      if (code == pat) res = {1'b1, IDX_W'(2 * WIDTH - k)};
    end
    return res;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  state_t           state_p1;
  logic [IDX_W-1:0] ref_idx_p1;
  logic [GC_W-1:0]  good_cnt_p1;

  logic             legal_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [IDX_W-1:0] next_ref_p0;
  logic             step_ok_p0;
  logic             ev_illegal_p0;
  logic             ev_step_p0;
  logic             ev_wrap_p0;

  // Stage p0: decode and classify the incoming sample against the held reference
  always_comb begin
    {legal_p0, idx_p0} = decode(bus.q_in);
    next_ref_p0   = (ref_idx_p1 == LAST_IDX) ? '0 : ref_idx_p1 + 1'b1;
    step_ok_p0    = (idx_p0 == next_ref_p0);
    ev_illegal_p0 = bus.q_valid && !legal_p0;
    ev_step_p0    = bus.q_valid && legal_p0 && (state_p1 != NOREF) && !step_ok_p0;
    ev_wrap_p0    = bus.q_valid && legal_p0 && (state_p1 != NOREF) && step_ok_p0 &&
                    (ref_idx_p1 == LAST_IDX) && (idx_p0 == '0);
  end

  // Stage p1: tracker state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1      <= NOREF;
      ref_idx_p1    <= '0;
      good_cnt_p1   <= '0;
      bus.phase     <= '0;
      bus.phase_idx <= '0;
      bus.illegal   <= 1'b0;
      bus.step_err  <= 1'b0;
      bus.wrap      <= 1'b0;
      bus.locked    <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.illegal  <= ev_illegal_p0;
      bus.step_err <= ev_step_p0;
      bus.wrap     <= ev_wrap_p0;

      if (bus.q_valid) begin
        if (!legal_p0) begin
          // phase_idx deliberately keeps the last legal index
          bus.phase   <= '0;
          bus.locked  <= 1'b0;
          state_p1    <= NOREF;
          good_cnt_p1 <= '0;
        end else begin
          bus.phase     <= PH_W'(1) << idx_p0;
          bus.phase_idx <= idx_p0;
          ref_idx_p1    <= idx_p0;
          case (state_p1)
            NOREF: begin
              good_cnt_p1 <= '0;
              state_p1    <= TRACK;
            end
            TRACK: begin
              if (step_ok_p0) begin
                good_cnt_p1 <= good_cnt_p1 + 1'b1;
                if (int'(good_cnt_p1) + 1 >= LOCK_CNT) begin
                  state_p1   <= LOCKED;
                  bus.locked <= 1'b1;
                end
              end else begin
                good_cnt_p1 <= '0;
              end
            end
            LOCKED: begin
              if (!step_ok_p0) begin
                state_p1    <= TRACK;
                good_cnt_p1 <= '0;
                bus.locked  <= 1'b0;
              end
            end
            default: begin
              state_p1    <= NOREF;
              good_cnt_p1 <= '0;
              bus.locked  <= 1'b0;
            end
          endcase
        end
      end

      // A clear coinciding with a new event leaves that event counted
      if (bus.err_clr) begin
        bus.err_count <= (ev_illegal_p0 || ev_step_p0) ? ERR_W'(1) : '0;
      end else if (ev_illegal_p0 || ev_step_p0) begin
        bus.err_count <= sat_inc(bus.err_count);
      end
    end
  end
endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Directed-vector bench for johnson_seq_monitor: a default instance
// (ERR_W=8) and a narrow-counter instance (ERR_W=2) for saturation.
module tb_johnson_seq_monitor;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  johnson_seq_monitor_if #(.WIDTH(4), .ERR_W(8)) bus  ();
  johnson_seq_monitor_if #(.WIDTH(4), .ERR_W(2)) bus2 ();

  johnson_seq_monitor #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  johnson_seq_monitor #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one valid sample to dut; returns 1ns after the capturing edge.
  task automatic send(input logic [3:0] code, input logic clr);
    @(negedge clk);
    bus.q_in    = code;
    bus.q_valid = 1'b1;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    bus.q_valid = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic send2(input logic [3:0] code, input logic clr);
    @(negedge clk);
    bus2.q_in    = code;
    bus2.q_valid = 1'b1;
    bus2.err_clr = clr;
    @(posedge clk);
    #1;
    bus2.q_valid = 1'b0;
    bus2.err_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++; if (bus.phase !== 8'h00) begin fails++; $display("FAIL reset_phase: got %h expected 00", bus.phase); end
    tests++; if (bus.phase_idx !== 3'd0) begin fails++; $display("FAIL reset_idx: got %0d expected 0", bus.phase_idx); end
    tests++; if ({bus.illegal, bus.step_err, bus.wrap, bus.locked} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b expected 0000", {bus.illegal, bus.step_err, bus.wrap, bus.locked}); end
    tests++; if (bus.err_count !== 8'd0) begin fails++; $display("FAIL reset_err: got %0d expected 0", bus.err_count); end
    tests++; if (bus2.err_count !== 2'd0) begin fails++; $display("FAIL reset_err2: got %0d expected 0", bus2.err_count); end
  endtask

  task automatic test_sequence;
    logic [3:0] codes [9];
    logic [2:0] exps  [9];
    logic [7:0] ph;
    codes = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    exps  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 9; i++) begin
      send(codes[i], 1'b0);
      ph = 8'd1 << exps[i];
      tests++; if (bus.phase_idx !== exps[i]) begin fails++; $display("FAIL seq_idx[%0d]: got %0d expected %0d", i, bus.phase_idx, exps[i]); end
      tests++; if (bus.phase !== ph) begin fails++; $display("FAIL seq_phase[%0d]: got %b expected %b", i, bus.phase, ph); end
      tests++; if (bus.locked !== (i >= 3)) begin fails++; $display("FAIL seq_locked[%0d]: got %b expected %b", i, bus.locked, (i >= 3)); end
      tests++; if (bus.wrap !== (i == 8)) begin fails++; $display("FAIL seq_wrap[%0d]: got %b expected %b", i, bus.wrap, (i == 8)); end
      tests++; if ({bus.illegal, bus.step_err} !== 2'b00) begin fails++; $display("FAIL seq_errs[%0d]: got %b expected 00", i, {bus.illegal, bus.step_err}); end
      tests++; if (bus.err_count !== 8'd0) begin fails++; $display("FAIL seq_errcnt[%0d]: got %0d expected 0", i, bus.err_count); end
    end
  endtask

  task automatic test_step_err;
    send(4'b1000, 1'b0);
    send(4'b1100, 1'b0);
    send(4'b1110, 1'b0);
    tests++; if ({bus.locked, bus.phase_idx} !== {1'b1, 3'd3}) begin fails++; $display("FAIL step_pre: got locked=%b idx=%0d expected locked=1 idx=3", bus.locked, bus.phase_idx); end
    send(4'b0011, 1'b0);
    tests++; if (bus.step_err !== 1'b1) begin fails++; $display("FAIL step_flag: got %b expected 1", bus.step_err); end
    tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL step_locked: got %b expected 0", bus.locked); end
    tests++; if (bus.phase !== 8'b0100_0000) begin fails++; $display("FAIL step_phase: got %b expected 01000000", bus.phase); end
    tests++; if (bus.err_count !== 8'd1) begin fails++; $display("FAIL step_errcnt: got %0d expected 1", bus.err_count); end
    send(4'b0001, 1'b0);
    tests++; if ({bus.locked, bus.step_err} !== 2'b00) begin fails++; $display("FAIL relock_a: got %b expected 00", {bus.locked, bus.step_err}); end
    send(4'b0000, 1'b0);
    tests++; if ({bus.locked, bus.wrap} !== 2'b01) begin fails++; $display("FAIL relock_b: got locked/wrap %b expected 01", {bus.locked, bus.wrap}); end
    send(4'b1000, 1'b0);
    tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL relock_c: got %b expected 1", bus.locked); end
  endtask

  task automatic test_illegal;
    send(4'b1010, 1'b0);
    tests++; if (bus.illegal !== 1'b1) begin fails++; $display("FAIL ill_flag: got %b expected 1", bus.illegal); end
    tests++; if (bus.phase !== 8'h00) begin fails++; $display("FAIL ill_phase: got %b expected 0", bus.phase); end
    tests++; if (bus.phase_idx !== 3'd1) begin fails++; $display("FAIL ill_idx: got %0d expected 1", bus.phase_idx); end
    tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL ill_locked: got %b expected 0", bus.locked); end
    tests++; if (bus.err_count !== 8'd2) begin fails++; $display("FAIL ill_errcnt: got %0d expected 2", bus.err_count); end
    send(4'b1100, 1'b0);
    tests++; if ({bus.illegal, bus.step_err} !== 2'b00) begin fails++; $display("FAIL ill_next: got %b expected 00", {bus.illegal, bus.step_err}); end
    tests++; if (bus.phase_idx !== 3'd2) begin fails++; $display("FAIL ill_next_idx: got %0d expected 2", bus.phase_idx); end
    send(4'b1110, 1'b0);
    send(4'b1111, 1'b0);
    send(4'b0111, 1'b0);
    tests++; if ({bus.locked, bus.phase_idx} !== {1'b1, 3'd5}) begin fails++; $display("FAIL ill_relock: got locked=%b idx=%0d expected locked=1 idx=5", bus.locked, bus.phase_idx); end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.q_in = 4'b1010;
      @(posedge clk);
      #1;
      tests++; if ({bus.locked, bus.phase_idx, bus.phase} !== {1'b1, 3'd5, 8'b0010_0000}) begin
        fails++; $display("FAIL hold_level[%0d]: got locked=%b idx=%0d phase=%b expected 1/5/00100000", i, bus.locked, bus.phase_idx, bus.phase); end
      tests++; if ({bus.illegal, bus.step_err, bus.wrap} !== 3'b000 || bus.err_count !== 8'd2) begin
        fails++; $display("FAIL hold_pulse[%0d]: got pulses=%b err=%0d expected 000/2", i, {bus.illegal, bus.step_err, bus.wrap}, bus.err_count); end
    end
    send(4'b0011, 1'b0);
    tests++; if ({bus.locked, bus.step_err, bus.phase_idx} !== {2'b10, 3'd6}) begin
      fails++; $display("FAIL hold_resume: got locked=%b step=%b idx=%0d expected 1/0/6", bus.locked, bus.step_err, bus.phase_idx); end
  endtask

  task automatic test_saturate;
    logic [1:0] exp_cnt;
    for (int i = 0; i < 5; i++) begin
      send2(4'b0101, 1'b0);
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      tests++; if ({bus2.illegal, bus2.err_count} !== {1'b1, exp_cnt}) begin
        fails++; $display("FAIL sat[%0d]: got illegal=%b err=%0d expected 1/%0d", i, bus2.illegal, bus2.err_count, exp_cnt); end
    end
    send2(4'b1001, 1'b1);
    tests++; if (bus2.err_count !== 2'd1) begin fails++; $display("FAIL sat_clr_event: got %0d expected 1", bus2.err_count); end
    send2(4'b0000, 1'b1);
    tests++; if (bus2.err_count !== 2'd0) begin fails++; $display("FAIL sat_clr_only: got %0d expected 0", bus2.err_count); end
  endtask

  task automatic test_reset_mid;
    tests++; if ({bus.locked, bus.err_count} !== {1'b1, 8'd2}) begin fails++; $display("FAIL rmid_pre: got locked=%b err=%0d expected 1/2", bus.locked, bus.err_count); end
    @(negedge clk);
    rst         = 1'b1;
    bus.q_in    = 4'b0001;
    bus.q_valid = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.q_valid = 1'b0;
    tests++; if ({bus.phase, bus.phase_idx, bus.illegal, bus.step_err, bus.wrap, bus.locked, bus.err_count} !== '0) begin
      fails++; $display("FAIL rmid_zero: got phase=%b idx=%0d flags=%b err=%0d expected all 0", bus.phase, bus.phase_idx,
                        {bus.illegal, bus.step_err, bus.wrap, bus.locked}, bus.err_count); end
    send(4'b0111, 1'b0);
    tests++; if ({bus.step_err, bus.locked, bus.phase_idx} !== {2'b00, 3'd5}) begin
      fails++; $display("FAIL rmid_first: got step=%b locked=%b idx=%0d expected 0/0/5", bus.step_err, bus.locked, bus.phase_idx); end
    send(4'b0011, 1'b0);
    tests++; if ({bus.step_err, bus.locked, bus.phase_idx} !== {2'b00, 3'd6}) begin
      fails++; $display("FAIL rmid_ref5: got step=%b locked=%b idx=%0d expected 0/0/6", bus.step_err, bus.locked, bus.phase_idx); end
    send(4'b0000, 1'b0);
    tests++; if ({bus.step_err, bus.wrap, bus.err_count} !== {2'b10, 8'd1}) begin
      fails++; $display("FAIL rmid_skip: got step=%b wrap=%b err=%0d expected 1/0/1", bus.step_err, bus.wrap, bus.err_count); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.q_in = '0;  bus.q_valid = 1'b0;  bus.err_clr = 1'b0;
    bus2.q_in = '0; bus2.q_valid = 1'b0; bus2.err_clr = 1'b0;
    test_reset();
    test_sequence();
    test_step_err();
    test_illegal();
    test_hold();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
